// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: PC-xor-history indexed table of saturating counters.
// Optional GSHARE_STATS_EN adds saturating update/mispredict event counters.
module gshare_branch_predictor #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned HIST_WIDTH  = 8,
  parameter int unsigned CTR_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  predict_valid,
  input  logic [31:0]           predict_pc,
  output logic                  predict_taken,
  output logic [HIST_WIDTH-1:0] predict_ghr,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic [HIST_WIDTH-1:0] update_ghr,
  input  logic                  update_taken,
  input  logic                  update_mispredict
`ifdef GSHARE_STATS_EN
  ,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int unsigned DEPTH = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  logic [CTR_WIDTH-1:0]   table_q [DEPTH];
  logic [HIST_WIDTH-1:0]  ghr_q;
  logic [HIST_WIDTH-1:0]  ghr_d;
  logic [INDEX_WIDTH-1:0] lookup_idx;
  logic [INDEX_WIDTH-1:0] update_idx;
  logic [CTR_WIDTH-1:0]   upd_ctr;
  logic [CTR_WIDTH-1:0]   upd_ctr_next;
  logic                   unused_pc_bits;

  assign unused_pc_bits = ^{predict_pc[31:INDEX_WIDTH+2], predict_pc[1:0],
                            update_pc[31:INDEX_WIDTH+2], update_pc[1:0]};

  // Lookup reads the pre-update table, so a same-index update shows next cycle.
  always_comb begin
    lookup_idx    = predict_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
    update_idx    = update_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(update_ghr);
    predict_taken = table_q[lookup_idx][CTR_WIDTH-1];
    predict_ghr   = ghr_q;
  end

  // Saturating increment/decrement of the resolved entry.
  always_comb begin
    upd_ctr      = table_q[update_idx];
    upd_ctr_next = upd_ctr;
    if (update_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - 1'b1;
    end
  end

  // Speculative shift on lookup; mispredict recovery takes priority.
  always_comb begin
    ghr_d = ghr_q;
    if (predict_valid) ghr_d = HIST_WIDTH'({ghr_q, predict_taken});
    if (update_valid && update_mispredict) ghr_d = HIST_WIDTH'({update_ghr, update_taken});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= CTR_INIT;
    end else if (update_valid) begin
      table_q[update_idx] <= upd_ctr_next;
    end
  end

`ifdef GSHARE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (update_valid) begin
      if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if (update_mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed self-checking bench for gshare_branch_predictor (default parameters).
// Define GSHARE_STATS_EN to also exercise the statistics counters.
module tb_gshare_branch_predictor;

  logic        clk;
  logic        rst;
  logic        predict_valid;
  logic [31:0] predict_pc;
  logic        predict_taken;
  logic [7:0]  predict_ghr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [7:0]  update_ghr;
  logic        update_taken;
  logic        update_mispredict;
`ifdef GSHARE_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int n_cmp;
  int n_err;

  gshare_branch_predictor #(
    .INDEX_WIDTH(8),
    .HIST_WIDTH (8),
    .CTR_WIDTH  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .predict_valid    (predict_valid),
    .predict_pc       (predict_pc),
    .predict_taken    (predict_taken),
    .predict_ghr      (predict_ghr),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict)
`ifdef GSHARE_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    predict_valid     = 1'b0;
    predict_pc        = 32'h0;
    update_valid      = 1'b0;
    update_pc         = 32'h0;
    update_ghr        = 8'h0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  // Reset across one rising edge; returns at a falling edge with rst low.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One update cycle, presented at a falling edge; returns at the next falling edge.
  task automatic upd(input logic [31:0] pc, input logic [7:0] ghr,
                     input logic taken, input logic misp);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_ghr        = ghr;
    update_taken      = taken;
    update_mispredict = misp;
    @(posedge clk);
    @(negedge clk);
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    predict_valid = 1'b1;
    predict_pc    = 32'h40;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_err++; $display("FAIL reset_taken got %0b want 0", predict_taken);
    end
    n_cmp++;
    if (predict_ghr !== 8'h00) begin
      n_err++; $display("FAIL reset_ghr got %02h want 00", predict_ghr);
    end
    @(negedge clk);
    predict_valid = 1'b0;
    n_cmp++;
    if (predict_ghr !== 8'h00) begin
      n_err++; $display("FAIL reset_ghr_after_shift got %02h want 00", predict_ghr);
    end
  endtask

  task automatic test_saturate_up();
    do_reset();
    predict_pc = 32'h40;
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (predict_taken !== 1'b1) begin
      n_err++; $display("FAIL sat_up_ctr2 got %0b want 1", predict_taken);
    end
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    // Held at 3: one decrement must still predict taken.
    upd(32'h40, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (predict_taken !== 1'b1) begin
      n_err++; $display("FAIL sat_up_hold got %0b want 1", predict_taken);
    end
    upd(32'h40, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_err++; $display("FAIL sat_up_ctr1 got %0b want 0", predict_taken);
    end
  endtask

  task automatic test_saturate_down();
    do_reset();
    predict_pc = 32'h80;
    upd(32'h80, 8'h00, 1'b0, 1'b0);
    upd(32'h80, 8'h00, 1'b0, 1'b0);
    upd(32'h80, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_err++; $display("FAIL sat_down_hold got %0b want 0", predict_taken);
    end
    upd(32'h80, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (predict_taken !== 1'b1) begin
      n_err++; $display("FAIL sat_down_ctr2 got %0b want 1", predict_taken);
    end
  endtask

  task automatic test_ghr_shift();
    do_reset();
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    predict_valid = 1'b1;
    predict_pc    = 32'h40;
    @(negedge clk);
    n_cmp++;
    if (predict_ghr !== 8'h01) begin
      n_err++; $display("FAIL shift_1 got %02h want 01", predict_ghr);
    end
    predict_pc = 32'h44;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1) begin
      n_err++; $display("FAIL shift_xor_taken got %0b want 1", predict_taken);
    end
    @(negedge clk);
    n_cmp++;
    if (predict_ghr !== 8'h03) begin
      n_err++; $display("FAIL shift_2 got %02h want 03", predict_ghr);
    end
    predict_pc = 32'h40;
    @(negedge clk);
    predict_valid = 1'b0;
    n_cmp++;
    if (predict_ghr !== 8'h06) begin
      n_err++; $display("FAIL shift_3 got %02h want 06", predict_ghr);
    end
  endtask

  task automatic test_mispredict_recovery();
    do_reset();
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    upd(32'h0, 8'h02, 1'b1, 1'b1);
    n_cmp++;
    if (predict_ghr !== 8'h05) begin
      n_err++; $display("FAIL recover_load got %02h want 05", predict_ghr);
    end
    predict_valid     = 1'b1;
    predict_pc        = 32'h54;
    update_valid      = 1'b1;
    update_pc         = 32'h0;
    update_ghr        = 8'hA0;
    update_taken      = 1'b0;
    update_mispredict = 1'b1;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1) begin
      n_err++; $display("FAIL recover_pred got %0b want 1", predict_taken);
    end
    @(negedge clk);
    update_valid = 1'b0;
    n_cmp++;
    if (predict_ghr !== 8'h40) begin
      n_err++; $display("FAIL recover_override got %02h want 40", predict_ghr);
    end
    @(negedge clk);
    predict_valid = 1'b0;
    n_cmp++;
    if (predict_ghr !== 8'h80) begin
      n_err++; $display("FAIL shift_after_recover got %02h want 80", predict_ghr);
    end
    update_mispredict = 1'b1;
    update_ghr        = 8'h0F;
    update_taken      = 1'b1;
    @(negedge clk);
    update_mispredict = 1'b0;
    n_cmp++;
    if (predict_ghr !== 8'h80) begin
      n_err++; $display("FAIL idle_ghr_hold got %02h want 80", predict_ghr);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    predict_valid = 1'b1;
    predict_pc    = 32'h40;
    update_valid  = 1'b1;
    update_pc     = 32'h40;
    update_ghr    = 8'h00;
    update_taken  = 1'b1;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_pre got %0b want 0", predict_taken);
    end
    @(negedge clk);
    predict_valid = 1'b0;
    update_valid  = 1'b0;
    n_cmp++;
    if (predict_taken !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_post got %0b want 1", predict_taken);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    predict_pc = 32'h40;
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    update_valid      = 1'b1;
    update_pc         = 32'h40;
    update_ghr        = 8'hFF;
    update_taken      = 1'b0;
    update_mispredict = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0) begin
      n_err++; $display("FAIL async_rst_taken got %0b want 0", predict_taken);
    end
    n_cmp++;
    if (predict_ghr !== 8'h00) begin
      n_err++; $display("FAIL async_rst_ghr got %02h want 00", predict_ghr);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
    n_cmp++;
    if (predict_ghr !== 8'h00) begin
      n_err++; $display("FAIL async_rst_no_recover got %02h want 00", predict_ghr);
    end
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (predict_taken !== 1'b1) begin
      n_err++; $display("FAIL async_rst_no_write got %0b want 1", predict_taken);
    end
  endtask

`ifdef GSHARE_STATS_EN
  task automatic test_stats();
    do_reset();
    n_cmp++;
    if (stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
      n_err++; $display("FAIL stats_reset got %0d/%0d want 0/0", stat_updates, stat_mispredicts);
    end
    upd(32'h40, 8'h00, 1'b1, 1'b0);
    upd(32'h44, 8'h00, 1'b0, 1'b1);
    update_mispredict = 1'b1;
    @(negedge clk);
    update_mispredict = 1'b0;
    upd(32'h48, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (stat_updates !== 32'd3) begin
      n_err++; $display("FAIL stats_updates got %0d want 3", stat_updates);
    end
    n_cmp++;
    if (stat_mispredicts !== 32'd1) begin
      n_err++; $display("FAIL stats_mispredicts got %0d want 1", stat_mispredicts);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_saturate_up();
    test_saturate_down();
    test_ghr_shift();
    test_mispredict_recovery();
    test_same_cycle();
    test_async_reset();
`ifdef GSHARE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
